// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states,
// datapath widths, instruction size and the NOP encoding.
package fetch_unit_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_DRAIN
    } fetch_state_e;

    // Force a fetch address onto an instruction boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory request/response, branch
// redirect and the decode-side valid/ready handshake.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instruction} pairs. Simultaneous push and
// pop are both honoured, including when full; flush empties it at once.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; data carries no reset, validity comes from the count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches, tracks the single pending
// response, buffers results in a prefetch FIFO and handles redirects.
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_stall
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    fetch_state_e      state_q;
    logic [XLEN-1:0]   pc_p0;
    logic [XLEN-1:0]   pc_p1;
    logic              vld_p1;
    logic [CW-1:0]     occ;
    logic [CW:0]       inflight;
    logic              grant;
    logic              redirect;
    logic              push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [2*XLEN-1:0] head;

    assign redirect      = bus.redirect_valid;
    assign inflight      = {1'b0, occ} + {{CW{1'b0}}, vld_p1};
    assign bus.imem_req  = (state_q == ST_RUN) && (inflight < DEPTH_W);
    assign bus.imem_addr = pc_p0;
    assign grant         = bus.imem_req && bus.imem_gnt;

    // A response is kept only in RUN and only if no redirect kills it this cycle.
    assign push = vld_p1 && bus.imem_rvalid && (state_q == ST_RUN) && !redirect
                  && (!fifo_full || bus.id_ready);

    assign bus.id_valid = !fifo_empty;
    assign bus.id_instr = fifo_empty ? '0 : head[XLEN-1:0];
    assign bus.id_pc    = fifo_empty ? '0 : head[2*XLEN-1:XLEN];

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .pop   (bus.id_ready),
        .din   ({pc_p1, bus.imem_rdata}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occ)
    );

    // Control FSM: boot delay, fetch PC advance, redirect and drain of a killed response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_BOOT;
            pc_p0   <= RESET_PC;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= grant;
            unique case (state_q)
                ST_BOOT: begin
                    state_q <= ST_RUN;
                    if (redirect) pc_p0 <= align_pc(bus.redirect_pc);
                end
                ST_RUN: begin
                    if (redirect) begin
                        pc_p0 <= align_pc(bus.redirect_pc);
                        if (grant || vld_p1) state_q <= ST_DRAIN;
                    end else if (grant) begin
                        pc_p0 <= pc_p0 + XLEN'(INSTR_BYTES);
                    end
                end
                ST_DRAIN: begin
                    if (redirect) pc_p0 <= align_pc(bus.redirect_pc);
                    else          state_q <= ST_RUN;
                end
                default: state_q <= ST_BOOT;
            endcase
        end
    end

    // PC of the outstanding request, paired with its response one cycle later.
    always_ff @(posedge clk) begin
        if (grant) pc_p1 <= pc_p0;
    end

`ifdef FETCH_PERF_EN
    // Count decode transfers and cycles where decode was starved.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (bus.id_valid && bus.id_ready)  perf_fetched <= perf_fetched + 32'd1;
            if (bus.id_ready && !bus.id_valid) perf_stall   <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A memory responder answers every
// grant one cycle later with a word derived from its address; a stream
// model checks fetch addresses and delivered instructions in program order.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Values sampled just before the most recent clock edge.
    logic        s_grant, s_xfer, s_valid, s_ready, s_redir;
    logic [31:0] s_gaddr, s_xpc, s_xinstr, s_rpc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // One clock: sample, clock edge, then answer the grant just taken.
    task automatic cycle();
        #2;
        s_grant  = bus.imem_req && bus.imem_gnt;
        s_gaddr  = bus.imem_addr;
        s_valid  = bus.id_valid;
        s_ready  = bus.id_ready;
        s_xfer   = s_valid && s_ready;
        s_xpc    = bus.id_pc;
        s_xinstr = bus.id_instr;
        s_redir  = bus.redirect_valid;
        s_rpc    = bus.redirect_pc;
        @(posedge clk);
        #1;
        bus.imem_rvalid = s_grant;
        bus.imem_rdata  = s_grant ? mem_word(s_gaddr) : 32'hDEAD_BEEF;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.id_valid); end
        checks++; if (bus.id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", bus.id_instr); end
        checks++; if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", bus.id_pc); end
        rst = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b expected 0", bus.imem_req); end
        #1;
        cycle();
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL run_req: got %b expected 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL run_addr: got %h expected %h", bus.imem_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_g, exp_x;
        int nx;
        do_reset();
        bus.imem_gnt = 1'b1; bus.id_ready = 1'b1;
        exp_g = RESET_PC; exp_x = RESET_PC; nx = 0;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            if (s_grant) begin
                checks++; if (s_gaddr !== exp_g) begin errors++; $display("FAIL stream_addr: got %h expected %h", s_gaddr, exp_g); end
                exp_g += 32'd4;
            end
            checks++;
            if (bus.id_valid !== (i == 3)) begin errors++; $display("FAIL stream_latency: cycle %0d got %b expected %b", i, bus.id_valid, (i == 3)); end
        end
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (s_grant) begin
                checks++; if (s_gaddr !== exp_g) begin errors++; $display("FAIL stream_addr: got %h expected %h", s_gaddr, exp_g); end
                exp_g += 32'd4;
            end
            if (s_xfer) begin
                nx++;
                checks++;
                if (s_xpc !== exp_x || s_xinstr !== mem_word(exp_x)) begin
                    errors++; $display("FAIL stream_pc: got pc %h instr %h expected pc %h instr %h", s_xpc, s_xinstr, exp_x, mem_word(exp_x));
                end
                exp_x += 32'd4;
            end
        end
        checks++; if (nx != 6) begin errors++; $display("FAIL stream_rate: got %0d transfers expected 6", nx); end
    endtask

    task automatic test_backpressure();
        int ng;
        logic [31:0] exp_g, exp_x;
        do_reset();
        bus.imem_gnt = 1'b1; bus.id_ready = 1'b0;
        ng = 0; exp_g = RESET_PC; exp_x = RESET_PC;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (s_grant) begin
                ng++;
                checks++; if (s_gaddr !== exp_g) begin errors++; $display("FAIL bp_addr: got %h expected %h", s_gaddr, exp_g); end
                exp_g += 32'd4;
            end
            if (s_valid) begin
                checks++;
                if (s_xpc !== RESET_PC || s_xinstr !== mem_word(RESET_PC)) begin
                    errors++; $display("FAIL bp_head: got pc %h instr %h expected pc %h", s_xpc, s_xinstr, RESET_PC);
                end
            end
        end
        checks++; if (ng != DEPTH) begin errors++; $display("FAIL bp_grants: got %0d expected %0d", ng, DEPTH); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_req: got %b expected 0", bus.imem_req); end
        // Release backpressure from a full FIFO: order must be preserved.
        bus.id_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_grant) begin
                checks++; if (s_gaddr !== exp_g) begin errors++; $display("FAIL full_addr: got %h expected %h", s_gaddr, exp_g); end
                exp_g += 32'd4;
            end
            if (s_xfer) begin
                checks++;
                if (s_xpc !== exp_x || s_xinstr !== mem_word(exp_x)) begin
                    errors++; $display("FAIL full_order: got pc %h expected %h", s_xpc, exp_x);
                end
                exp_x += 32'd4;
            end
        end
        checks++; if (exp_x < 32'd60) begin errors++; $display("FAIL full_rate: got next pc %h expected at least 3c", exp_x); end
    endtask

    // Redirect with a pending response; then redirect again while draining.
    task automatic redirect_case(input logic [31:0] tgt1, input logic do_second, input logic [31:0] tgt2);
        logic [31:0] tgt;
        logic got_g, got_x;
        bus.imem_gnt = 1'b1; bus.id_ready = 1'b1;
        repeat (5) cycle();
        bus.redirect_valid = 1'b1; bus.redirect_pc = tgt1;
        cycle();
        bus.redirect_valid = 1'b0;
        tgt = tgt1 & ~32'h3;
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b expected 0", bus.id_valid); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL redir_drain: got req %b expected 0", bus.imem_req); end
        if (do_second) begin
            bus.redirect_valid = 1'b1; bus.redirect_pc = tgt2;
            cycle();
            bus.redirect_valid = 1'b0;
            tgt = tgt2 & ~32'h3;
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL redir_drain2: got req %b expected 0", bus.imem_req); end
        end
        got_g = 1'b0; got_x = 1'b0;
        for (int i = 0; i < 10 && !got_x; i++) begin
            cycle();
            if (s_grant && !got_g) begin
                got_g = 1'b1;
                checks++; if (s_gaddr !== tgt) begin errors++; $display("FAIL redir_addr: got %h expected %h", s_gaddr, tgt); end
            end
            if (s_xfer) begin
                got_x = 1'b1;
                checks++;
                if (s_xpc !== tgt || s_xinstr !== mem_word(tgt)) begin
                    errors++; $display("FAIL redir_pc: got pc %h instr %h expected pc %h", s_xpc, s_xinstr, tgt);
                end
            end
        end
        checks++; if (!got_x) begin errors++; $display("FAIL redir_timeout: got no transfer expected pc %h", tgt); end
    endtask

    task automatic test_redirect();
        do_reset();
        redirect_case(32'h0000_0103, 1'b0, 32'h0);
        redirect_case(32'h0000_0040, 1'b1, 32'h0000_020A);
    endtask

    task automatic test_reset_midop();
        logic got_g, got_x;
        do_reset();
        bus.imem_gnt = 1'b1; bus.id_ready = 1'b1;
        repeat (4) cycle();
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.id_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: got valid %b req %b expected 0 0", bus.id_valid, bus.imem_req);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
        got_g = 1'b0; got_x = 1'b0;
        for (int i = 0; i < 10 && !got_x; i++) begin
            cycle();
            if (i < 2) begin
                checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale: cycle %0d got valid %b expected 0", i, bus.id_valid); end
            end
            if (s_grant && !got_g) begin
                got_g = 1'b1;
                checks++; if (s_gaddr !== RESET_PC) begin errors++; $display("FAIL midrst_addr: got %h expected %h", s_gaddr, RESET_PC); end
            end
            if (s_xfer) begin
                got_x = 1'b1;
                checks++;
                if (s_xpc !== RESET_PC || s_xinstr !== mem_word(RESET_PC)) begin
                    errors++; $display("FAIL midrst_first: got pc %h instr %h expected pc %h", s_xpc, s_xinstr, RESET_PC);
                end
            end
        end
        checks++; if (!got_x) begin errors++; $display("FAIL midrst_timeout: got no transfer expected pc %h", RESET_PC); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, exp_fetch;
        int nx;
        do_reset();
        exp_pc = RESET_PC; exp_fetch = RESET_PC; nx = 0;
        for (int i = 0; i < 3000; i++) begin
            bus.imem_gnt       = ($urandom_range(0, 3) != 0);
            bus.id_ready       = ($urandom_range(0, 9) < 6);
            bus.redirect_valid = ($urandom_range(0, 19) == 0);
            bus.redirect_pc    = $urandom;
            cycle();
            if (s_xfer) begin
                nx++;
                checks++;
                if (s_xpc !== exp_pc || s_xinstr !== mem_word(exp_pc)) begin
                    errors++; $display("FAIL rnd_xfer: got pc %h instr %h expected pc %h instr %h", s_xpc, s_xinstr, exp_pc, mem_word(exp_pc));
                end
                exp_pc += 32'd4;
            end
            if (s_grant && !s_redir) begin
                checks++; if (s_gaddr !== exp_fetch) begin errors++; $display("FAIL rnd_addr: got %h expected %h", s_gaddr, exp_fetch); end
                exp_fetch += 32'd4;
            end
            if (s_redir) begin
                exp_pc = s_rpc & ~32'h3;
                exp_fetch = exp_pc;
                checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rnd_flush: got %b expected 0", bus.id_valid); end
            end else if (s_valid && !s_ready) begin
                checks++;
                if (bus.id_valid !== 1'b1 || bus.id_pc !== s_xpc || bus.id_instr !== s_xinstr) begin
                    errors++; $display("FAIL rnd_stable: got valid %b pc %h expected valid 1 pc %h", bus.id_valid, bus.id_pc, s_xpc);
                end
            end
            checks++;
            if ((exp_fetch - exp_pc) > 32'(4 * DEPTH)) begin
                errors++; $display("FAIL rnd_occupancy: got %0d words in flight expected at most %0d", (exp_fetch - exp_pc) / 4, DEPTH);
            end
        end
        checks++; if (nx < 300) begin errors++; $display("FAIL rnd_progress: got %0d transfers expected at least 300", nx); end
    endtask

`ifdef FETCH_PERF_EN
    task automatic perf_phase(input logic rdy, input logic gnt, input int n, inout int nx, inout int ns);
        bus.id_ready = rdy; bus.imem_gnt = gnt;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (s_xfer) nx++;
            if (s_ready && !s_valid) ns++;
        end
    endtask

    task automatic test_perf();
        int nx, ns;
        do_reset();
        #1;
        checks++; if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
            errors++; $display("FAIL perf_reset: got %0d %0d expected 0 0", perf_fetched, perf_stall);
        end
        nx = 0; ns = 0;
        perf_phase(1'b0, 1'b1, 8, nx, ns);
        perf_phase(1'b1, 1'b0, 7, nx, ns);
        perf_phase(1'b0, 1'b1, 8, nx, ns);
        perf_phase(1'b1, 1'b0, 4, nx, ns);
        perf_phase(1'b0, 1'b1, 8, nx, ns);
        perf_phase(1'b1, 1'b0, 2, nx, ns);
        perf_phase(1'b0, 1'b0, 1, nx, ns);
        checks++; if (nx != 10 || ns != 3) begin errors++; $display("FAIL perf_scenario: got %0d transfers %0d starved expected 10 3", nx, ns); end
        checks++; if (perf_fetched !== 32'd10) begin errors++; $display("FAIL perf_fetched: got %0d expected 10", perf_fetched); end
        checks++; if (perf_stall !== 32'd3) begin errors++; $display("FAIL perf_stall: got %0d expected 3", perf_stall); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_reset_midop();
        test_random();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4; prefetch FIFO entries, power of two, 2 to 16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000; first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-007 imem_gnt  input  1  memory accepts the request this cycle.
REQ-008 imem_rvalid  input  1  read data valid; arrives exactly one cycle after each grant.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 redirect_valid  input  1  branch/jump taken; restart fetch at redirect_pc.
REQ-011 redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 0.
REQ-012 id_valid  output  1  instruction available to decode.
REQ-013 id_ready  input  1  decode accepts the instruction.
REQ-014 id_instr  output  32  instruction at the FIFO head.
REQ-015 id_pc  output  32  PC of id_instr.

Function
REQ-016 The FSM SHALL have states BOOT, RUN and DRAIN.
REQ-017 BOOT SHALL last exactly one cycle after reset release, issue no request, then go to RUN.
REQ-018 In RUN, imem_req SHALL be 1 when FIFO occupancy plus pending responses is less than DEPTH.
REQ-019 Each grant SHALL advance the fetch PC by 4 and set pending for one cycle; at most one response is pending.
REQ-020 Each rvalid response SHALL be written into the FIFO together with its PC, unless it is being discarded.
REQ-021 A transfer to decode SHALL occur when id_valid=1 and id_ready=1; id_valid SHALL equal FIFO not-empty.
REQ-022 id_instr and id_pc SHALL remain stable while id_valid=1 and id_ready=0.
REQ-023 Latency SHALL be 2 cycles from the grant to id_valid when the FIFO is empty (grant, then rvalid write, then visible).
REQ-024 A FIFO write and a FIFO pop in the same cycle SHALL both occur; occupancy stays unchanged, even when the FIFO is full.
REQ-025 Pointers SHALL wrap modulo DEPTH; occupancy SHALL never exceed DEPTH and never underflow.
REQ-026 A redirect SHALL flush the FIFO the same cycle, drive id_valid=0 the next cycle, and load the fetch PC with redirect_pc.
REQ-027 If a redirect coincides with a grant or a pending response, the FSM SHALL enter DRAIN, discard that response, then return to RUN.
REQ-028 imem_req SHALL be 0 in DRAIN; a redirect during DRAIN SHALL update the fetch PC and remain in DRAIN.
REQ-029 A redirect SHALL take priority over a decode pop in the same cycle; the popped instruction is still counted as consumed.
REQ-030 The block SHALL ignore imem_rvalid when no response is pending.

Reset
REQ-031 While rst=0: state BOOT, fetch PC = RESET_PC, FIFO empty, pending=0, imem_req=0, id_valid=0, id_instr=0, id_pc=0.
REQ-032 A reset asserted mid-operation SHALL abort any pending response, which is not written after reset release.

Configuration
REQ-033 With macro FETCH_PERF_EN defined, the block SHALL add output perf_fetched (32) and output perf_stall (32).
REQ-034 perf_fetched SHALL count decode transfers.
REQ-035 perf_stall SHALL count cycles with id_ready=1 and id_valid=0.
REQ-036 Both counters SHALL reset to 0 and wrap at 2^32.
REQ-037 Without FETCH_PERF_EN, the ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-038 A shared package SHALL hold the FSM state enum, the XLEN=32 constant, the INSTR_BYTES=4 constant and the NOP encoding 32'h0000_0013.
REQ-039 The FIFO SHALL be one sub-module, fetch_fifo, with parameters WIDTH=64 and DEPTH, and ports push, pop, full, empty.

Verification
REQ-040 Reset, then grant every cycle and id_ready=1 -> addresses 0,4,8,...; id_pc sequence 0,4,8 with first id_valid 3 cycles after reset release.
REQ-041 id_ready=0 with DEPTH=4 -> exactly 4 grants, then imem_req=0; head holds pc 0 stable.
REQ-042 Redirect to 0x100 while a response is pending -> that response is discarded, DRAIN is visited, and the next id_pc is 0x100.
REQ-043 Full FIFO with simultaneous pop and rvalid write -> occupancy stays 4 and order is preserved.
REQ-044 rst=0 asserted while a response is pending -> after release, the first imem_addr is RESET_PC and no stale instruction appears.
REQ-045 With FETCH_PERF_EN, 10 transfers and 3 starved ready cycles -> perf_fetched=10 and perf_stall=3.
